// File: rtl/bcd_rtc.sv
// bcd_rtc: BCD real-time clock that keeps date and time from loaded telegrams.
//
// A prescaler divides clk down to one tick per second. Each tick advances a
// two-digit BCD cascade (second, minute, hour, day, month, year, weekday).
// A load replaces the date/time (seconds become 00) after validation. A load
// that fails validation is dropped and flagged on load_err. After a valid load,
// synced stays high for HOLDOVER_S further seconds while the clock runs free.
//
// Parameters
//   CLK_HZ      input clock frequency in Hz (>= 2)
//   HOLDOVER_S  seconds of free running after a load before synced drops (>= 1)
// Ports
//   clk, reset_n                    clock, asynchronous active-low reset
//   load_valid / load_ready         load handshake
//   ld_year..ld_minute (BCD)        date/time to load
//   ld_day_of_week                  weekday to load, 1=Monday .. 7=Sunday
//   year..second (BCD)              current date/time, registered
//   day_of_week                     current weekday, registered
//   sec_pulse, min_pulse            one-cycle tick strobes
//   load_err                        one-cycle strobe for a rejected load
//   synced                          time comes from a recent load
module bcd_rtc #(
   parameter int unsigned CLK_HZ     = 10_000_000,
   parameter int unsigned HOLDOVER_S = 3600
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic [7:0] ld_year,
   input  logic [7:0] ld_month,
   input  logic [7:0] ld_day,
   input  logic [7:0] ld_hour,
   input  logic [7:0] ld_minute,
   input  logic [2:0] ld_day_of_week,
   output logic [7:0] year,
   output logic [7:0] month,
   output logic [7:0] day,
   output logic [7:0] hour,
   output logic [7:0] minute,
   output logic [7:0] second,
   output logic [2:0] day_of_week,
   output logic       sec_pulse,
   output logic       min_pulse,
   output logic       load_err,
   output logic       synced
);

   localparam int unsigned PW = $clog2(CLK_HZ);
   localparam int unsigned HW = $clog2(HOLDOVER_S + 1);
   localparam logic [PW-1:0] PrescMax = PW'(CLK_HZ - 1);
   localparam logic [HW-1:0] HoldInit = HW'(HOLDOVER_S);

   logic [7:0]    year_q, year_d, month_q, month_d, day_q, day_d;
   logic [7:0]    hour_q, hour_d, minute_q, minute_d, second_q, second_d;
   logic [2:0]    dow_q, dow_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          sec_pulse_q, sec_pulse_d, min_pulse_q, min_pulse_d;
   logic          load_err_q, load_err_d, synced_q, synced_d;
   logic          load_ready_q, load_ready_d;

   logic          accept, ld_ok, load_good, wrap;

   function automatic logic is_bcd(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) begin
         return {v[7:4] + 4'd1, 4'd0};
      end
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Year mod 4 on BCD: (10*tens + units) mod 4 == (2*tens + units) mod 4.
   function automatic logic is_leap(input logic [7:0] y);
      if (y[4]) begin
         return (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
      end
      return (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
   endfunction

   function automatic logic [7:0] month_len(input logic [7:0] m, input logic [7:0] y);
      case (m)
         8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
         8'h02:                      return is_leap(y) ? 8'h29 : 8'h28;
         default:                    return 8'h31;
      endcase
   endfunction

   always_comb begin
      // BCD compares are numeric once every nibble is known to be <= 9.
      ld_ok = is_bcd(ld_year) && is_bcd(ld_month) && is_bcd(ld_day) &&
              is_bcd(ld_hour) && is_bcd(ld_minute) &&
              (ld_month >= 8'h01) && (ld_month <= 8'h12) &&
              (ld_day >= 8'h01) && (ld_day <= month_len(ld_month, ld_year)) &&
              (ld_hour <= 8'h23) && (ld_minute <= 8'h59) &&
              (ld_day_of_week >= 3'd1) && (ld_day_of_week <= 3'd7);
   end

   assign accept    = load_valid && load_ready_q;
   assign load_good = accept && ld_ok;
   assign wrap      = (presc_q == PrescMax);

   always_comb begin
      year_d       = year_q;
      month_d      = month_q;
      day_d        = day_q;
      hour_d       = hour_q;
      minute_d     = minute_q;
      second_d     = second_q;
      dow_d        = dow_q;
      hold_d       = hold_q;
      synced_d     = synced_q;
      sec_pulse_d  = 1'b0;
      min_pulse_d  = 1'b0;
      load_err_d   = accept && !ld_ok;
      load_ready_d = !accept;
      presc_d      = wrap ? '0 : presc_q + 1'b1;

      if (load_good) begin
         // A load wins over a coincident wrap: no tick, prescaler restarts.
         year_d   = ld_year;
         month_d  = ld_month;
         day_d    = ld_day;
         hour_d   = ld_hour;
         minute_d = ld_minute;
         second_d = 8'h00;
         dow_d    = ld_day_of_week;
         presc_d  = '0;
         hold_d   = HoldInit;
         synced_d = 1'b1;
      end else if (wrap) begin
         sec_pulse_d = 1'b1;
         if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
            if (hold_q == HW'(1)) begin
               synced_d = 1'b0;
            end
         end
         if (second_q == 8'h59) begin
            second_d    = 8'h00;
            min_pulse_d = 1'b1;
            if (minute_q == 8'h59) begin
               minute_d = 8'h00;
               if (hour_q == 8'h23) begin
                  hour_d = 8'h00;
                  dow_d  = (dow_q == 3'd7) ? 3'd1 : dow_q + 3'd1;
                  if (day_q == month_len(month_q, year_q)) begin
                     day_d = 8'h01;
                     if (month_q == 8'h12) begin
                        month_d = 8'h01;
                        year_d  = (year_q == 8'h99) ? 8'h00 : bcd_inc(year_q);
                     end else begin
                        month_d = bcd_inc(month_q);
                     end
                  end else begin
                     day_d = bcd_inc(day_q);
                  end
               end else begin
                  hour_d = bcd_inc(hour_q);
               end
            end else begin
               minute_d = bcd_inc(minute_q);
            end
         end else begin
            second_d = bcd_inc(second_q);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         year_q       <= 8'h00;
         month_q      <= 8'h01;
         day_q        <= 8'h01;
         hour_q       <= 8'h00;
         minute_q     <= 8'h00;
         second_q     <= 8'h00;
         dow_q        <= 3'd1;
         presc_q      <= '0;
         hold_q       <= '0;
         sec_pulse_q  <= 1'b0;
         min_pulse_q  <= 1'b0;
         load_err_q   <= 1'b0;
         synced_q     <= 1'b0;
         load_ready_q <= 1'b1;
      end else begin
         year_q       <= year_d;
         month_q      <= month_d;
         day_q        <= day_d;
         hour_q       <= hour_d;
         minute_q     <= minute_d;
         second_q     <= second_d;
         dow_q        <= dow_d;
         presc_q      <= presc_d;
         hold_q       <= hold_d;
         sec_pulse_q  <= sec_pulse_d;
         min_pulse_q  <= min_pulse_d;
         load_err_q   <= load_err_d;
         synced_q     <= synced_d;
         load_ready_q <= load_ready_d;
      end
   end

   assign year        = year_q;
   assign month       = month_q;
   assign day         = day_q;
   assign hour        = hour_q;
   assign minute      = minute_q;
   assign second      = second_q;
   assign day_of_week = dow_q;
   assign sec_pulse   = sec_pulse_q;
   assign min_pulse   = min_pulse_q;
   assign load_err    = load_err_q;
   assign synced      = synced_q;
   assign load_ready  = load_ready_q;

endmodule

// File: tb/tb_bcd_rtc.sv
// tb_bcd_rtc: self-checking bench for bcd_rtc with CLK_HZ=4, HOLDOVER_S=3.
// A table of load records drives the main checks; hand-written sequences
// cover the power-up count, load-on-wrap, holdover expiry and async reset.
module tb_bcd_rtc;

   localparam int unsigned Hz = 4;

   logic       clk;
   logic       reset_n;
   logic       load_valid;
   logic       load_ready;
   logic [7:0] ld_year, ld_month, ld_day, ld_hour, ld_minute;
   logic [2:0] ld_day_of_week;
   logic [7:0] year, month, day, hour, minute, second;
   logic [2:0] day_of_week;
   logic       sec_pulse, min_pulse, load_err, synced;

   bcd_rtc #(
      .CLK_HZ     (Hz),
      .HOLDOVER_S (3)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .load_valid     (load_valid),
      .load_ready     (load_ready),
      .ld_year        (ld_year),
      .ld_month       (ld_month),
      .ld_day         (ld_day),
      .ld_hour        (ld_hour),
      .ld_minute      (ld_minute),
      .ld_day_of_week (ld_day_of_week),
      .year           (year),
      .month          (month),
      .day            (day),
      .hour           (hour),
      .minute         (minute),
      .second         (second),
      .day_of_week    (day_of_week),
      .sec_pulse      (sec_pulse),
      .min_pulse      (min_pulse),
      .load_err       (load_err),
      .synced         (synced)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] y, mo, d, h, mi, s;
      logic [2:0] dow;
      logic       sy;
   } snap_t;

   typedef struct {
      logic [7:0] y, mo, d, h, mi;
      logic [2:0] dow;
      logic       ok;
      int         run;
      int         mins;
      snap_t      post;
      snap_t      fin;
   } row_t;

   int    total = 0;
   int    bad   = 0;
   snap_t exp_q[$];
   row_t  rows[12];

   function automatic snap_t mk(input logic [7:0] y, mo, d, h, mi, s, input logic [2:0] dow,
                                input logic sy);
      return {y, mo, d, h, mi, s, dow, sy};
   endfunction

   function automatic snap_t cur_snap();
      return {year, month, day, hour, minute, second, day_of_week, synced};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   task automatic check_snap(input string name);
      snap_t e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = exp_q.pop_front();
         chk(name, 64'(cur_snap()), 64'(e));
      end
   endtask

   task automatic chk_reset(input string name);
      chk(name, 64'({cur_snap(), sec_pulse, min_pulse, load_err, load_ready}),
          64'({mk(8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 3'd1, 1'b0), 4'b0001}));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (min_pulse) chk("min_with_sec", 64'(sec_pulse), 64'd1);
   endtask

   // Waits for n sec_pulses within a bounded number of cycles.
   task automatic wait_pulses(input int n, output int mins);
      int got    = 0;
      int budget = n * Hz + 8;
      mins = 0;
      while (got < n && budget > 0) begin
         tick();
         budget--;
         if (sec_pulse) got++;
         if (min_pulse) mins++;
      end
      chk("pulse_wait", 64'(got), 64'(n));
   endtask

   task automatic drive_load(input logic [7:0] y, mo, d, h, mi, input logic [2:0] dow);
      ld_year        = y;
      ld_month       = mo;
      ld_day         = d;
      ld_hour        = h;
      ld_minute      = mi;
      ld_day_of_week = dow;
      load_valid     = 1'b1;
   endtask

   initial begin
      int m;
      int cnt;
      int pos[4];
      int n;

      rows[0]  = '{8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 3'd7, 1'b1, 60, 1,
                   mk(8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h00, 3'd7, 1'b1),
                   mk(8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 3'd1, 1'b0)};
      rows[1]  = '{8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 3'd3, 1'b1, 60, 1,
                   mk(8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h00, 3'd3, 1'b1),
                   mk(8'h24, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00, 3'd4, 1'b0)};
      rows[2]  = '{8'h23, 8'h02, 8'h28, 8'h23, 8'h59, 3'd2, 1'b1, 60, 1,
                   mk(8'h23, 8'h02, 8'h28, 8'h23, 8'h59, 8'h00, 3'd2, 1'b1),
                   mk(8'h23, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 3'd3, 1'b0)};
      rows[3]  = '{8'h23, 8'h01, 8'h15, 8'h12, 8'h34, 3'd5, 1'b1, 0, 0,
                   mk(8'h23, 8'h01, 8'h15, 8'h12, 8'h34, 8'h00, 3'd5, 1'b1),
                   mk(8'h23, 8'h01, 8'h15, 8'h12, 8'h34, 8'h00, 3'd5, 1'b1)};
      // Invalid rows: each is preceded by one aligning second, so the expected
      // snapshot is the previous one plus one second and one holdover step.
      rows[4]  = '{8'h23, 8'h13, 8'h01, 8'h10, 8'h00, 3'd1, 1'b0, 0, 0,
                   mk(8'h23, 8'h01, 8'h15, 8'h12, 8'h34, 8'h01, 3'd5, 1'b1),
                   mk(8'h23, 8'h01, 8'h15, 8'h12, 8'h34, 8'h01, 3'd5, 1'b1)};
      rows[5]  = '{8'h23, 8'h04, 8'h31, 8'h10, 8'h00, 3'd1, 1'b0, 0, 0,
                   mk(8'h23, 8'h01, 8'h15, 8'h12, 8'h34, 8'h02, 3'd5, 1'b1),
                   mk(8'h23, 8'h01, 8'h15, 8'h12, 8'h34, 8'h02, 3'd5, 1'b1)};
      rows[6]  = '{8'h23, 8'h05, 8'h10, 8'h24, 8'h00, 3'd1, 1'b0, 0, 0,
                   mk(8'h23, 8'h01, 8'h15, 8'h12, 8'h34, 8'h03, 3'd5, 1'b0),
                   mk(8'h23, 8'h01, 8'h15, 8'h12, 8'h34, 8'h03, 3'd5, 1'b0)};
      rows[7]  = '{8'h23, 8'h05, 8'h10, 8'h10, 8'h1A, 3'd2, 1'b0, 0, 0,
                   mk(8'h23, 8'h01, 8'h15, 8'h12, 8'h34, 8'h04, 3'd5, 1'b0),
                   mk(8'h23, 8'h01, 8'h15, 8'h12, 8'h34, 8'h04, 3'd5, 1'b0)};
      rows[8]  = '{8'h23, 8'h05, 8'h10, 8'h10, 8'h10, 3'd0, 1'b0, 0, 0,
                   mk(8'h23, 8'h01, 8'h15, 8'h12, 8'h34, 8'h05, 3'd5, 1'b0),
                   mk(8'h23, 8'h01, 8'h15, 8'h12, 8'h34, 8'h05, 3'd5, 1'b0)};
      rows[9]  = '{8'h23, 8'h04, 8'h30, 8'h08, 8'h00, 3'd1, 1'b1, 2, 0,
                   mk(8'h23, 8'h04, 8'h30, 8'h08, 8'h00, 8'h00, 3'd1, 1'b1),
                   mk(8'h23, 8'h04, 8'h30, 8'h08, 8'h00, 8'h02, 3'd1, 1'b1)};
      rows[10] = '{8'h23, 8'h02, 8'h29, 8'h10, 8'h00, 3'd3, 1'b0, 0, 0,
                   mk(8'h23, 8'h04, 8'h30, 8'h08, 8'h00, 8'h03, 3'd1, 1'b0),
                   mk(8'h23, 8'h04, 8'h30, 8'h08, 8'h00, 8'h03, 3'd1, 1'b0)};
      rows[11] = '{8'h24, 8'h02, 8'h29, 8'h10, 8'h00, 3'd4, 1'b1, 0, 0,
                   mk(8'h24, 8'h02, 8'h29, 8'h10, 8'h00, 8'h00, 3'd4, 1'b1),
                   mk(8'h24, 8'h02, 8'h29, 8'h10, 8'h00, 8'h00, 3'd4, 1'b1)};

      reset_n    = 1'b0;
      load_valid = 1'b0;
      drive_load(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
      load_valid = 1'b0;
      tick();
      tick();
      chk_reset("reset_state");
      reset_n = 1'b1;

      // Free run from reset: pulses on cycles 4, 8, 12, 16.
      cnt = 0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (sec_pulse) begin
            if (cnt < 4) pos[cnt] = i;
            cnt++;
         end
      end
      chk("run16_count", 64'(cnt), 64'd4);
      for (int k = 0; k < 4; k++) chk($sformatf("run16_pos%0d", k), 64'(pos[k]), 64'(4 * (k + 1)));
      chk("run16_second", 64'(second), 64'h04);
      chk("run16_synced", 64'(synced), 64'd0);

      for (int i = 0; i < 12; i++) begin
         wait_pulses(1, m);
         drive_load(rows[i].y, rows[i].mo, rows[i].d, rows[i].h, rows[i].mi, rows[i].dow);
         exp_q.push_back(rows[i].post);
         tick();
         load_valid = 1'b0;
         check_snap($sformatf("row%0d_post", i));
         chk($sformatf("row%0d_err", i), 64'(load_err), 64'(!rows[i].ok));
         chk($sformatf("row%0d_ready_low", i), 64'(load_ready), 64'd0);
         chk($sformatf("row%0d_no_tick", i), 64'(sec_pulse), 64'd0);
         tick();
         chk($sformatf("row%0d_ready_back", i), 64'(load_ready), 64'd1);
         chk($sformatf("row%0d_err_gone", i), 64'(load_err), 64'd0);
         if (rows[i].run > 0) begin
            exp_q.push_back(rows[i].fin);
            wait_pulses(rows[i].run, m);
            check_snap($sformatf("row%0d_final", i));
            chk($sformatf("row%0d_mins", i), 64'(m), 64'(rows[i].mins));
         end
      end

      // Load coincident with a prescaler wrap.
      wait_pulses(1, m);
      tick();
      tick();
      tick();
      drive_load(8'h25, 8'h06, 8'h15, 8'h09, 8'h30, 3'd7);
      exp_q.push_back(mk(8'h25, 8'h06, 8'h15, 8'h09, 8'h30, 8'h00, 3'd7, 1'b1));
      tick();
      load_valid = 1'b0;
      chk("wrap_load_no_pulse", 64'(sec_pulse), 64'd0);
      check_snap("wrap_load_snap");
      n = 0;
      do begin
         tick();
         n++;
      end while (!sec_pulse && n < 10);
      chk("wrap_load_gap", 64'(n), 64'd4);
      chk("wrap_load_second", 64'(second), 64'h01);

      // Holdover expiry after three seconds without a load.
      drive_load(8'h25, 8'h06, 8'h15, 8'h09, 8'h45, 3'd2);
      exp_q.push_back(mk(8'h25, 8'h06, 8'h15, 8'h09, 8'h45, 8'h00, 3'd2, 1'b1));
      tick();
      load_valid = 1'b0;
      check_snap("hold_load");
      wait_pulses(1, m);
      chk("hold_p1", 64'(synced), 64'd1);
      wait_pulses(1, m);
      chk("hold_p2", 64'(synced), 64'd1);
      wait_pulses(1, m);
      chk("hold_p3", 64'(synced), 64'd0);
      chk("hold_second", 64'(second), 64'h03);

      // Reset asserted between edges while a load is offered.
      tick();
      tick();
      drive_load(8'h25, 8'h07, 8'h01, 8'h00, 8'h00, 3'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset("reset_async");
      tick();
      chk_reset("reset_held");
      load_valid = 1'b0;
      reset_n    = 1'b1;
      exp_q.push_back(mk(8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 3'd1, 1'b0));
      tick();
      check_snap("after_reset");
      chk("after_reset_ready", 64'(load_ready), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
